// File: rtl/uart_tx.sv
// UART serial transmitter: accepts a parallel word over valid/ready and shifts
// start, data (LSB first), optional parity and stop bits onto txd, paced by bps_clk.
module uart_tx #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bps_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_en,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned    CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic           LAST_STOP = 1'(STOP_BITS - 1);
    localparam bit             HAS_PAR   = (PARITY != 0);
    localparam logic           ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state, state_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_d;
    logic                 stop_cnt, stop_cnt_d;
    logic                 par_bit, par_bit_d;
    logic                 txd_d, uart_en_d, tx_busy_d, tx_done_d;
    logic                 accept;

    assign tx_ready = (state == IDLE);
    assign accept   = tx_valid && tx_ready;

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            txd      <= 1'b1;
            uart_en  <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            bit_cnt  <= bit_cnt_d;
            stop_cnt <= stop_cnt_d;
            par_bit  <= par_bit_d;
            txd      <= txd_d;
            uart_en  <= uart_en_d;
            tx_busy  <= tx_busy_d;
            tx_done  <= tx_done_d;
        end
    end

    // Next state, next line value and frame bookkeeping
    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        bit_cnt_d  = bit_cnt;
        stop_cnt_d = stop_cnt;
        par_bit_d  = par_bit;
        txd_d      = txd;
        tx_done_d  = 1'b0;

        case (state)
            IDLE: begin
                txd_d = 1'b1;
                if (accept) begin
                    shreg_d   = tx_data;
                    par_bit_d = (^tx_data) ^ ODD_PAR;
                    state_d   = SYNC;
                end
            end
            // First generator tick is a partial period; it only opens the start bit.
            SYNC: begin
                if (bps_clk) begin
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (bps_clk) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    txd_d     = shreg[0];
                end
            end
            DATA: begin
                if (bps_clk) begin
                    if (bit_cnt == LAST_BIT) begin
                        stop_cnt_d = 1'b0;
                        if (HAS_PAR) begin
                            state_d = PAR;
                            txd_d   = par_bit;
                        end else begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        shreg_d   = shreg >> 1;
                        bit_cnt_d = bit_cnt + CNT_W'(1);
                        txd_d     = shreg[1];
                    end
                end
            end
            PAR: begin
                if (bps_clk) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                    txd_d      = 1'b1;
                end
            end
            STOP: begin
                if (bps_clk) begin
                    if (stop_cnt == LAST_STOP) begin
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                        txd_d     = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        uart_en_d = (state_d != IDLE);
        tx_busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1, 8E1, 8O1 and 8N2 instances share clock,
// reset, baud tick and data; each has its own tx_valid.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       bps_clk;
    logic [7:0] tx_data;
    logic [3:0] valid_v;
    logic [3:0] ready_v, en_v, txd_v, busy_v, done_v;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx u_8n1 (
        .clk(clk), .rst(rst), .bps_clk(bps_clk), .tx_data(tx_data),
        .tx_valid(valid_v[0]), .tx_ready(ready_v[0]), .uart_en(en_v[0]),
        .txd(txd_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0])
    );

    uart_tx #(.PARITY(2)) u_8e1 (
        .clk(clk), .rst(rst), .bps_clk(bps_clk), .tx_data(tx_data),
        .tx_valid(valid_v[1]), .tx_ready(ready_v[1]), .uart_en(en_v[1]),
        .txd(txd_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1])
    );

    uart_tx #(.PARITY(1)) u_8o1 (
        .clk(clk), .rst(rst), .bps_clk(bps_clk), .tx_data(tx_data),
        .tx_valid(valid_v[2]), .tx_ready(ready_v[2]), .uart_en(en_v[2]),
        .txd(txd_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2])
    );

    uart_tx #(.STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .bps_clk(bps_clk), .tx_data(tx_data),
        .tx_valid(valid_v[3]), .tx_ready(ready_v[3]), .uart_en(en_v[3]),
        .txd(txd_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3])
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int s, input string tag, input logic done);
        chk($sformatf("%s_txd", tag), txd_v[s], 1'b1);
        chk($sformatf("%s_uart_en", tag), en_v[s], 1'b0);
        chk($sformatf("%s_tx_busy", tag), busy_v[s], 1'b0);
        chk($sformatf("%s_tx_ready", tag), ready_v[s], 1'b1);
        chk($sformatf("%s_tx_done", tag), done_v[s], done);
    endtask

    // Present a word at a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input int s, input logic [7:0] d, input bit hold);
        tx_data    = d;
        valid_v[s] = 1'b1;
        chk($sformatf("acc%0d_ready", s), ready_v[s], 1'b1);
        @(negedge clk);
        if (!hold) valid_v[s] = 1'b0;
    endtask

    // Exp bit i is the i-th line bit after the SYNC tick; 16 cycles per bit.
    task automatic run_frame(input int s, input string tag, input logic [11:0] exp,
                             input int nbits, input int abort_bit,
                             input bit mid_chg, input logic [7:0] mid_d);
        chk($sformatf("%s_en_rise", tag), en_v[s], 1'b1);
        chk($sformatf("%s_busy_rise", tag), busy_v[s], 1'b1);
        chk($sformatf("%s_ready_low", tag), ready_v[s], 1'b0);
        chk($sformatf("%s_sync_txd", tag), txd_v[s], 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk($sformatf("%s_sync_txd", tag), txd_v[s], 1'b1);
            chk($sformatf("%s_sync_en", tag), en_v[s], 1'b1);
        end
        bps_clk = 1'b1;
        @(negedge clk);
        bps_clk = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < 16; c++) begin
                if (i == abort_bit && c == 5) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk_idle(s, $sformatf("%s_rst", tag), 1'b0);
                    return;
                end
                if (mid_chg && i == 4 && c == 0) tx_data = mid_d;
                chk($sformatf("%s_b%0d_c%0d_txd", tag, i, c), txd_v[s], exp[i]);
                if (c == 0) begin
                    chk($sformatf("%s_b%0d_en", tag, i), en_v[s], 1'b1);
                    chk($sformatf("%s_b%0d_done", tag, i), done_v[s], 1'b0);
                    chk($sformatf("%s_b%0d_ready", tag, i), ready_v[s], 1'b0);
                end
                bps_clk = (c == 15);
                @(negedge clk);
            end
        end
        bps_clk = 1'b0;
        chk_idle(s, $sformatf("%s_end", tag), 1'b1);
    endtask

    initial begin
        rst     = 1'b1;
        bps_clk = 1'b0;
        valid_v = '0;
        tx_data = 8'h00;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) chk_idle(s, $sformatf("reset%0d", s), 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        accept(0, 8'hA5, 1'b0);
        run_frame(0, "n1_a5", {2'b00, 1'b1, 8'hA5, 1'b0}, 10, -1, 1'b0, 8'h00);
        @(negedge clk);
        chk("n1_a5_done_once", done_v[0], 1'b0);
        chk("n1_a5_en_after", en_v[0], 1'b0);

        // 8E1 0xA5: parity 0
        accept(1, 8'hA5, 1'b0);
        run_frame(1, "e1_a5", {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, -1, 1'b0, 8'h00);
        @(negedge clk);
        chk("e1_a5_done_once", done_v[1], 1'b0);

        // 8O1 0xA5: parity 1
        accept(2, 8'hA5, 1'b0);
        run_frame(2, "o1_a5", {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, -1, 1'b0, 8'h00);
        @(negedge clk);

        // 8O1 0x01: parity 0
        accept(2, 8'h01, 1'b0);
        run_frame(2, "o1_01", {1'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, -1, 1'b0, 8'h00);
        @(negedge clk);

        // 8N2 0xFF: low only in the start bit, two stop periods
        accept(3, 8'hFF, 1'b0);
        run_frame(3, "n2_ff", {1'b0, 2'b11, 8'hFF, 1'b0}, 11, -1, 1'b0, 8'h00);
        @(negedge clk);
        chk("n2_ff_done_once", done_v[3], 1'b0);

        // Valid held through the frame; data changes to 0x00 mid-frame
        accept(0, 8'h5A, 1'b1);
        run_frame(0, "hold_5a", {2'b00, 1'b1, 8'h5A, 1'b0}, 10, -1, 1'b1, 8'h00);
        @(negedge clk);
        valid_v[0] = 1'b0;
        run_frame(0, "b2b_00", {2'b00, 1'b1, 8'h00, 1'b0}, 10, -1, 1'b0, 8'h00);
        @(negedge clk);

        // Reset during data bit 3 of 0xA5, then a clean 0x3C frame
        accept(0, 8'hA5, 1'b0);
        run_frame(0, "abort_a5", {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 4, 1'b0, 8'h00);
        @(negedge clk);
        chk_idle(0, "abort_hold", 1'b0);
        accept(0, 8'h3C, 1'b0);
        run_frame(0, "post_3c", {2'b00, 1'b1, 8'h3C, 1'b0}, 10, -1, 1'b0, 8'h00);
        @(negedge clk);

        // Ticks in IDLE are ignored
        for (int k = 0; k < 10; k++) begin
            bps_clk = 1'b1;
            @(negedge clk);
            bps_clk = 1'b0;
            chk($sformatf("idle_tick%0d_txd", k), txd_v[0], 1'b1);
            chk($sformatf("idle_tick%0d_en", k), en_v[0], 1'b0);
            @(negedge clk);
            chk($sformatf("idle_gap%0d_busy", k), busy_v[0], 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter stage of the UART, directly downstream of the baud clock generator. Accepts parallel bytes over a valid/ready handshake, drives `uart_en` to start the baud generator, and shifts start, data (LSB first), optional parity and stop bits onto `txd`. Each bit boundary is paced by the one-cycle `bps_clk` tick.

## Interface
Parameters:
- `DATA_BITS`, default 8: data bits per frame. Legal values are 5 to 8.
- `PARITY`, default 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: number of stop bits. Legal values are 1 or 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `bps_clk`  in  1  baud tick from the generator. High for one `clk` cycle per bit period.
- `tx_data`  in  DATA_BITS  byte to send. Sampled only on accept.
- `tx_valid`  in  1  upstream has data.
- `tx_ready`  out  1  high only in IDLE. Accept occurs when `tx_valid && tx_ready`.
- `uart_en`  out  1  enable request to the baud generator.
- `txd`  out  1  serial line. Idles high.
- `tx_busy`  out  1  frame in progress (any state except IDLE).
- `tx_done`  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- States: IDLE, SYNC, START, DATA, PAR, STOP. PAR exists only when `PARITY != 0`.
- IDLE
  - `txd` = 1. On accept: latch `tx_data` into the shift register, compute the parity bit, go to SYNC.
  - `bps_clk` in IDLE is ignored.
- SYNC
  - `txd` = 1 and `uart_en` = 1.
  - Purpose: discard the generator's first, partial-period tick.
  - On `bps_clk`: go to START and drive `txd` = 0.
- START: on `bps_clk`, drive data bit 0 and go to DATA. Bit counter = 0.
- DATA
  - On `bps_clk`: if bit counter == DATA_BITS-1, go to PAR (drive parity) or to STOP (drive 1). Otherwise shift, increment the counter, and drive the next bit.
- PAR: on `bps_clk`, go to STOP and drive 1.
- STOP
  - Stop counter counts ticks.
  - On the STOP_BITS-th tick: go to IDLE, pulse `tx_done`, and leave `txd` = 1.
- Parity:
  - Even mode: bit = XOR of the data bits.
  - Odd mode: bit = the inverse of that XOR.
- Width rules:
  - Bit counter is clog2(DATA_BITS) bits wide.
  - Stop counter is 1 bit wide.
  - No arithmetic wrap is reachable: counters reset on each state entry.
- `tx_valid` outside IDLE is ignored, and `tx_data` is not re-sampled. Upstream must hold `tx_valid` until `tx_ready`.
- Back-to-back frames: an accept in the IDLE cycle right after STOP is legal. `uart_en` then drops for at most one cycle, and the new frame re-enters SYNC.

## Timing
- All outputs are registered except `tx_ready`, which is decoded from the state register.
- Reset values: `txd` = 1, `uart_en` = 0, `tx_busy` = 0, `tx_done` = 0, `tx_ready` = 1. State goes to IDLE and counters clear.
- Accept at cycle N: `uart_en` and `tx_busy` go high at N+1.
- A `bps_clk` tick at cycle T updates `txd` at T+1. Every line transition is therefore exactly one cycle after a tick.
- Frame length is 1 + DATA_BITS + (PARITY?1:0) + STOP_BITS bit periods, measured from the first post-SYNC tick.
- `tx_done` is high in the cycle after the final stop tick. In that same cycle `uart_en` = 0, `tx_busy` = 0 and `tx_ready` = 1.
- Reset asserted mid-frame: at the next edge all outputs return to their reset values and any partial frame is abandoned. `txd` returns high immediately, with no glitch-low cycle.
- `bps_clk` and accept cannot coincide with a state change: accept happens only in IDLE, where ticks are ignored.

## Test plan
- 8N1, byte 0xA5, tick every 16 cycles:
  - After the SYNC tick, `txd` = 0,1,0,1,0,0,1,0,1,1. Each bit lasts 16 cycles.
  - `tx_done` pulses once. `uart_en` is low afterwards.
- 8E1 0xA5 gives parity bit 0. 8O1 0xA5 gives parity bit 1. 8O1 0x01 gives parity bit 0. Frame is 11 bits.
- STOP_BITS=2 with 0xFF: `txd` is low only during the start bit. The stop interval is 2 periods. `tx_done` comes one cycle after the second stop tick.
- Handshake and ignored inputs:
  - `tx_valid` is held through a frame while `tx_data` changes to 0x00 mid-frame. The serialised byte is still 0x5A.
  - The second byte is accepted only when `tx_ready` = 1 after `tx_done`.
- Reset at DATA bit 3 of 0xA5: next cycle `txd` = 1, `uart_en` = 0, `tx_ready` = 1. A following 0x3C frame then transmits correctly.
- Ticks in IDLE: 10 `bps_clk` pulses with `tx_valid` = 0. `txd` stays 1 and `uart_en` stays 0.
